river_crossing_ctrl: RTL and testbench
======================================

Name: river_crossing_ctrl

Overview:
- Sequential game controller for the farmer/cabbage/goat/wolf river-crossing puzzle.
- Sits directly upstream of the combinational unsafe-bank alarm stage.
- Holds the bank position of each item and drives them as F, C, G, W (0 = start bank, 1 = far bank).
- Executes boat crossings on player request, reads the alarm result (ac_in) back after every move, and declares win/loss.

Parameters:
- CROSS_CYCLES, 4: clock cycles a crossing takes, from acceptance to position update; legal range is 1 or more.
- CNT_W, 8: width of the move counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- move_req  in  1  synchronous level from button conditioning; a rising edge requests a crossing.
- sel  in  2  passenger selection: 00 farmer alone, 01 cabbage, 10 goat, 11 wolf.
- restart  in  1  synchronous, 1-cycle pulse; returns the game to its initial state.
- ac_in  in  1  alarm from the downstream stage, computed from F/C/G/W.
- F, C, G, W  out  1 each  bank positions.
- busy  out  1  crossing in progress (MOVING or CHECK).
- reject  out  1  1-cycle pulse when a request is illegal.
- won  out  1  puzzle solved.
- lost  out  1  unsafe bank reached.
- move_cnt  out  CNT_W  count of completed crossings.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0, all outputs are 0, state is IDLE, timer is 0 and the edge-detect register is 0.
  - Reset taking effect mid-crossing abandons the move; positions are not updated.
- All outputs are registered. The edge detector registers the previous move_req; a request is move_req=1 while prev=0.
- States: IDLE, MOVING, CHECK, WON, LOST.
- IDLE, request with sel=00:
  - Accept. Latch sel, load timer with CROSS_CYCLES-1, go to MOVING.
- IDLE, request with sel != 00:
  - Accept only if the selected item's position equals F.
  - Otherwise pulse reject for exactly one cycle, stay in IDLE, and leave positions and counter unchanged.
- MOVING:
  - Timer decrements each cycle.
  - On the edge where timer==0: toggle F (and the latched passenger if sel!=00), increment move_cnt, go to CHECK.
  - Positions therefore change CROSS_CYCLES edges after the accepting edge.
- CHECK: one cycle so ac_in settles on the new positions; sample ac_in at the next edge.
  - ac_in=1: go to LOST, lost=1.
  - ac_in=0 and F=C=G=W=1: go to WON, won=1.
  - Otherwise: go to IDLE.
- busy is 1 in MOVING and CHECK and 0 otherwise.
- Requests arriving in MOVING, CHECK, WON or LOST are ignored. They are not queued and do not pulse reject.
- move_cnt saturates at 2^CNT_W-1; crossings still execute once it is saturated.
- restart, in any state: next edge sets positions 0000, move_cnt 0, won=lost=0, state IDLE.
  - restart has priority over a simultaneous request or timer expiry.
- ac_in is ignored outside CHECK.

Optional Feature:
- Macro RIVER_UNDO_EN.
- When defined:
  - Adds input port undo (1-cycle pulse) and a one-deep history register of {F,C,G,W} plus a valid bit.
  - History is written on every position update.
  - undo in IDLE or LOST with history valid restores the positions, decrements move_cnt (non-saturated case), clears lost, goes to IDLE, and clears the valid bit.
  - undo in other states, or with no valid history, pulses reject.
  - restart clears the valid bit. Priority order: restart, then undo, then request.
- When not defined: there is no undo port and no history logic; behaviour is exactly as above.

Decomposition:
- Shared package river_pkg holds:
  - state enum;
  - SEL_NONE/SEL_CABBAGE/SEL_GOAT/SEL_WOLF constants;
  - bank encoding constants BANK_START=0, BANK_FAR=1.
- Natural sub-module: crossing_timer.
  - Contains the load/decrement counter with a done output.
  - Parameterized by CROSS_CYCLES.

Test Plan:
- Initial move with goat: reset, sel=10, move_req rise, ac_in model = downstream truth table.
  - busy=1 for CROSS_CYCLES+1 cycles.
  - FCGW goes 0000 to 1010 after 4 edges; move_cnt=1; state returns to IDLE.
- Illegal passenger: from 1010 with sel=01 (C=0, F=1), request.
  - reject high exactly one cycle; FCGW stays 1010; move_cnt stays 1.
- Farmer alone at start: from 0000 with sel=00.
  - FCGW=1000, ac_in=1 in CHECK, lost=1.
  - Further requests are ignored; restart gives 0000, lost=0, move_cnt=0.
- Full 7-move solution (goat, back, cabbage, goat back, wolf, back, goat).
  - Final FCGW=1111, won=1, move_cnt=7, lost never asserted.
- Hazards:
  - move_req toggled during MOVING: ignored.
  - rst_n low mid-MOVING: immediate 0000, busy=0, move_cnt=0.
  - restart coincident with timer expiry: restart wins.
- With RIVER_UNDO_EN, from a lost 1000: undo gives 0000, lost=0, move_cnt=0; a second undo pulses reject.

Source files
------------

// File: rtl/river_pkg.sv
// Shared types and constants for the river-crossing game controller.
package river_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVING = 3'd1,
    CHECK  = 3'd2,
    WON    = 3'd3,
    LOST   = 3'd4
  } state_e;

  localparam logic [1:0] SEL_NONE    = 2'b00;
  localparam logic [1:0] SEL_CABBAGE = 2'b01;
  localparam logic [1:0] SEL_GOAT    = 2'b10;
  localparam logic [1:0] SEL_WOLF    = 2'b11;

  localparam logic BANK_START = 1'b0;
  localparam logic BANK_FAR   = 1'b1;

  // Bits of {F,C,G,W} that flip when the farmer crosses with passenger s.
  function automatic logic [3:0] cross_mask(logic [1:0] s);
    logic [3:0] m;
    case (s)
      SEL_CABBAGE: m = 4'b1100;
      SEL_GOAT:    m = 4'b1010;
      SEL_WOLF:    m = 4'b1001;
      default:     m = 4'b1000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crossing_timer.sv
// Load/decrement crossing timer; done_c is high while the count is zero.
module crossing_timer #(
  parameter int unsigned CROSS_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done_c
);

  localparam int unsigned TW = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(CROSS_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = LOAD_VAL;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/river_crossing_ctrl.sv
// Farmer/cabbage/goat/wolf game controller: crossings, alarm readback, win/loss.
// Define RIVER_UNDO_EN to add the one-deep undo port and history register.
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int unsigned CROSS_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             move_req,
  input  logic [1:0]       sel,
  input  logic             restart,
  input  logic             ac_in,
`ifdef RIVER_UNDO_EN
  input  logic             undo,
`endif
  output logic             F,
  output logic             C,
  output logic             G,
  output logic             W,
  output logic             busy,
  output logic             reject,
  output logic             won,
  output logic             lost,
  output logic [CNT_W-1:0] move_cnt
);

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             reject_q, reject_d;
  logic             busy_q, busy_d;
  logic             won_q, won_d;
  logic             lost_q, lost_d;
  logic             timer_load, timer_dec, timer_done;
  logic             req;
  logic [3:0]       req_mask;
  logic             req_legal;
`ifdef RIVER_UNDO_EN
  logic [3:0]       hist_q, hist_d;
  logic             hist_vld_q, hist_vld_d;
  logic             hist_inc_q, hist_inc_d;
`endif

  crossing_timer #(.CROSS_CYCLES(CROSS_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .dec    (timer_dec),
    .done_c (timer_done)
  );

  assign req       = move_req & ~prev_q;
  assign req_mask  = cross_mask(sel);
  // Passenger must be on the farmer's bank: masked bits all 0 or all 1.
  assign req_legal = ((pos_q & req_mask) == 4'b0000) || ((pos_q & req_mask) == req_mask);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    reject_d   = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
`ifdef RIVER_UNDO_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    hist_inc_d = hist_inc_q;
`endif
    if (restart) begin
      state_d = IDLE;
      pos_d   = {4{BANK_START}};
      cnt_d   = '0;
`ifdef RIVER_UNDO_EN
      hist_vld_d = 1'b0;
`endif
    end
`ifdef RIVER_UNDO_EN
    else if (undo) begin
      if ((state_q == IDLE || state_q == LOST) && hist_vld_q) begin
        state_d    = IDLE;
        pos_d      = hist_q;
        hist_vld_d = 1'b0;
        if (hist_inc_q) cnt_d = cnt_q - CNT_W'(1);
      end else begin
        reject_d = 1'b1;
      end
    end
`endif
    else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (req_legal) begin
              sel_d      = sel;
              timer_load = 1'b1;
              state_d    = MOVING;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        MOVING: begin
          if (timer_done) begin
            pos_d   = pos_q ^ cross_mask(sel_q);
            state_d = CHECK;
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
`ifdef RIVER_UNDO_EN
            hist_d     = pos_q;
            hist_vld_d = 1'b1;
            hist_inc_d = !(&cnt_q);
`endif
          end else begin
            timer_dec = 1'b1;
          end
        end
        CHECK: begin
          if (ac_in)                         state_d = LOST;
          else if (pos_q == {4{BANK_FAR}})   state_d = WON;
          else                               state_d = IDLE;
        end
        WON, LOST: ;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == MOVING) || (state_d == CHECK);
    won_d  = (state_d == WON);
    lost_d = (state_d == LOST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      prev_q   <= move_req;
      reject_q <= reject_d;
      busy_q   <= busy_d;
      won_q    <= won_d;
      lost_q   <= lost_d;
    end
  end

`ifdef RIVER_UNDO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      hist_inc_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      hist_inc_q <= hist_inc_d;
    end
  end
`endif

  assign {F, C, G, W} = pos_q;
  assign busy         = busy_q;
  assign reject       = reject_q;
  assign won          = won_q;
  assign lost         = lost_q;
  assign move_cnt     = cnt_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl with a downstream alarm model.
module tb_river_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       move_req;
  logic [1:0] sel;
  logic       restart;
  logic       ac_in;
`ifdef RIVER_UNDO_EN
  logic       undo;
`endif
  logic       F, C, G, W, busy, reject, won, lost;
  logic [7:0] move_cnt;

  int checks   = 0;
  int failures = 0;

  river_crossing_ctrl #(.CROSS_CYCLES(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .move_req (move_req),
    .sel      (sel),
    .restart  (restart),
    .ac_in    (ac_in),
`ifdef RIVER_UNDO_EN
    .undo     (undo),
`endif
    .F        (F),
    .C        (C),
    .G        (G),
    .W        (W),
    .busy     (busy),
    .reject   (reject),
    .won      (won),
    .lost     (lost),
    .move_cnt (move_cnt)
  );

  always #5 clk = ~clk;

  // Downstream alarm: goat left with cabbage or wolf on the farmer's opposite bank.
  assign ac_in = ((G == C) && (G != F)) || ((W == G) && (G != F));

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] pos;
    logic       rej;
    logic [7:0] cnt;
    logic       won;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request edge; returns after the accepting/rejecting edge.
  task automatic request(input logic [1:0] s);
    sel      = s;
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
  endtask

  // Counts busy samples from the accepting edge until idle (bounded).
  task automatic wait_idle(output int n);
    n = busy ? 1 : 0;
    for (int i = 0; i < 64 && busy; i++) begin
      tick();
      if (busy) n++;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic rej_seen;

    tbl[0] = '{sel: 2'b10, pos: 4'b1010, rej: 1'b0, cnt: 8'd1, won: 1'b0};
    tbl[1] = '{sel: 2'b01, pos: 4'b1010, rej: 1'b1, cnt: 8'd1, won: 1'b0};
    tbl[2] = '{sel: 2'b00, pos: 4'b0010, rej: 1'b0, cnt: 8'd2, won: 1'b0};
    tbl[3] = '{sel: 2'b01, pos: 4'b1110, rej: 1'b0, cnt: 8'd3, won: 1'b0};
    tbl[4] = '{sel: 2'b10, pos: 4'b0100, rej: 1'b0, cnt: 8'd4, won: 1'b0};
    tbl[5] = '{sel: 2'b01, pos: 4'b0100, rej: 1'b1, cnt: 8'd4, won: 1'b0};
    tbl[6] = '{sel: 2'b11, pos: 4'b1101, rej: 1'b0, cnt: 8'd5, won: 1'b0};
    tbl[7] = '{sel: 2'b00, pos: 4'b0101, rej: 1'b0, cnt: 8'd6, won: 1'b0};
    tbl[8] = '{sel: 2'b10, pos: 4'b1111, rej: 1'b0, cnt: 8'd7, won: 1'b1};

    rst_n = 1'b0; move_req = 1'b0; sel = 2'b00; restart = 1'b0;
`ifdef RIVER_UNDO_EN
    undo = 1'b0;
`endif
    #12;
    chk("reset_pos", {28'd0, F, C, G, W}, 32'h0);
    chk("reset_flags", {28'd0, busy, reject, won, lost}, 32'h0);
    chk("reset_cnt", move_cnt, 0);
    rst_n = 1'b1;
    tick();

    // First goat crossing with cycle-exact timing.
    request(2'b10);
    chk("goat_busy_accept", busy, 1);
    tick(); tick(); tick();
    chk("goat_pos_before", {28'd0, F, C, G, W}, 32'ha ^ 32'ha);
    tick();
    chk("goat_pos_after4", {28'd0, F, C, G, W}, 32'ha);
    chk("goat_cnt", move_cnt, 1);
    chk("goat_busy_check", busy, 1);
    tick();
    chk("goat_busy_idle", busy, 0);
    do_restart();
    chk("restart_pos", {28'd0, F, C, G, W}, 32'h0);
    chk("restart_cnt", move_cnt, 0);

    // Farmer alone from start loses; requests then ignored.
    request(2'b00);
    wait_idle(n);
    chk("lost_busy_cycles", n, 5);
    chk("lost_pos", {28'd0, F, C, G, W}, 32'h8);
    chk("lost_flag", lost, 1);
    request(2'b00);
    chk("lost_ignore_rej", reject, 0);
    chk("lost_ignore_busy", busy, 0);
    tick();
    chk("lost_ignore_pos", {28'd0, F, C, G, W}, 32'h8);
    chk("lost_ignore_cnt", move_cnt, 1);

`ifdef RIVER_UNDO_EN
    undo = 1'b1;
    tick();
    undo = 1'b0;
    chk("undo_pos", {28'd0, F, C, G, W}, 32'h0);
    chk("undo_lost", lost, 0);
    chk("undo_cnt", move_cnt, 0);
    chk("undo_rej0", reject, 0);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    chk("undo_again_rej", reject, 1);
    tick();
    chk("undo_again_rej_clr", reject, 0);
    request(2'b00);
    wait_idle(n);
`endif
    do_restart();
    chk("restart_lost", lost, 0);
    chk("restart_pos2", {28'd0, F, C, G, W}, 32'h0);
    chk("restart_cnt2", move_cnt, 0);

    // Full solution with interleaved illegal requests.
    for (int i = 0; i < 9; i++) begin
      request(tbl[i].sel);
      if (tbl[i].rej) begin
        chk($sformatf("v%0d_reject", i), reject, 1);
        chk($sformatf("v%0d_busy", i), busy, 0);
        tick();
        chk($sformatf("v%0d_reject_1cyc", i), reject, 0);
      end else begin
        chk($sformatf("v%0d_noreject", i), reject, 0);
        wait_idle(n);
        chk($sformatf("v%0d_busy_cycles", i), n, 5);
      end
      chk($sformatf("v%0d_pos", i), {28'd0, F, C, G, W}, {28'd0, tbl[i].pos});
      chk($sformatf("v%0d_cnt", i), move_cnt, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_won", i), won, {31'd0, tbl[i].won});
      chk($sformatf("v%0d_lost", i), lost, 0);
    end
    request(2'b00);
    tick();
    chk("won_ignore_busy", busy, 0);
    chk("won_ignore_pos", {28'd0, F, C, G, W}, 32'hf);
    do_restart();
    chk("won_restart", {28'd0, won, F, C, G, W}, 32'h0);

    // move_req toggling during MOVING is neither queued nor rejected.
    rej_seen = 1'b0;
    request(2'b10);
    move_req = 1'b1; tick(); rej_seen |= reject;
    move_req = 1'b0; tick(); rej_seen |= reject;
    move_req = 1'b1; tick(); rej_seen |= reject;
    move_req = 1'b0; tick(); rej_seen |= reject;
    chk("toggle_pos", {28'd0, F, C, G, W}, 32'ha);
    tick(); rej_seen |= reject;
    tick(); rej_seen |= reject;
    chk("toggle_busy", busy, 0);
    chk("toggle_rej", rej_seen, 0);
    chk("toggle_cnt", move_cnt, 1);

    // restart on the timer-expiry edge wins.
    request(2'b00);
    tick(); tick(); tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_exp_pos", {28'd0, F, C, G, W}, 32'h0);
    chk("rst_exp_cnt", move_cnt, 0);
    chk("rst_exp_busy", busy, 0);
    tick();
    chk("rst_exp_stay", {27'd0, busy, F, C, G, W}, 32'h0);

    // Async reset mid-crossing.
    request(2'b10);
    wait_idle(n);
    request(2'b00);
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("async_pos", {28'd0, F, C, G, W}, 32'h0);
    chk("async_busy", busy, 0);
    chk("async_cnt", move_cnt, 0);
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("async_after", {27'd0, busy, F, C, G, W}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
